address_unit: RTL and testbench
===============================

# address_unit

Parametrised address-generation unit for the CPU datapath, replacing the fixed 16-bit PC/AR pair. It holds the program counter, address register and a new stack pointer, all ADDR_W wide. A byte-serial assembler builds a full-width operand from successive DATA_W-wide bus bytes, and a selected address drives the memory address port. It sits between the control unit (strobes) and the 8-bit data bus / memory interface.

## Interface
- ADDR_W, 16: width of PC, AR, SP and assembled operand; must be a multiple of DATA_W, at least DATA_W.
- DATA_W, 8: data bus width.
- RESET_VECTOR, 'h0000: PC value after reset.
- SP_RESET, 'hFFFF (all ones): SP value after reset.
- NBYTES, ADDR_W/DATA_W: derived localparam, bytes per operand.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-low reset.
- DataBus  in  DATA_W  data bus; source for operand bytes and relative offsets.
- db_valid  in  1  DataBus holds a valid operand byte this cycle.
- asm_start  in  1  begin assembling a new operand.
- asm_abort  in  1  abandon assembly and return to idle.
- src_temp  in  1  load source: 1 = assembled operand, 0 = PC (AR/SP loads only).
- PC_load, PC_inc, PC_rel  in  1 each  program counter controls.
- AR_load, AR_inc, AR_dec  in  1 each  address register controls.
- SP_load, SP_push, SP_pop  in  1 each  stack pointer controls.
- addr_sel  in  2  address output select: 0 PC, 1 AR, 2 SP, 3 operand.
- ProgramCounter, AddressRegister, StackPointer  out  ADDR_W each  registers.
- Address  out  ADDR_W  combinational mux of the registers per addr_sel.
- asm_ready  out  1  operand complete and valid.
- load_err  out  1  one-cycle pulse: a load from the operand was attempted while asm_ready = 0.

## Operation
- Reset (rst = 0 at an edge): PC = RESET_VECTOR; AR = 0; SP = SP_RESET; operand = 0; byte count = 0; FSM = IDLE; asm_ready = 0; load_err = 0. Reset overrides every other input, including mid-assembly.
- Arithmetic is modulo 2^ADDR_W; carries are discarded.
- PC priority, highest first:
  - PC_rel: PC = PC + sign-extended DataBus.
  - PC_inc: PC + 1.
  - PC_load: PC = operand.
- PC_load always sources the operand. If asm_ready = 0, PC holds and load_err pulses.
- AR priority: AR_inc > AR_dec > AR_load. The load source is the operand when src_temp = 1, else PC.
- SP priority: SP_push > SP_pop > SP_load.
  - SP_push: SP − 1 (pre-decrement; Address with addr_sel = 2 shows the new value next cycle).
  - SP_pop: SP + 1.
  - SP_load: same sources as AR_load.
- Any load with an operand source while asm_ready = 0: target holds, load_err = 1 for one cycle.
- Assembler FSM:
  - IDLE: asm_start → COLLECT with count = 0.
  - COLLECT: on db_valid, operand[count*DATA_W +: DATA_W] = DataBus (little-endian, low byte first) and count increments. Capturing byte NBYTES−1 → READY. Cycles without db_valid hold.
  - READY: asm_ready = 1. The first successful operand-sourced load returns the FSM to IDLE, with the operand retained. asm_start → COLLECT (restart).
  - asm_abort in any state → IDLE, count = 0, operand retained. asm_abort has priority over asm_start in the same cycle.
- Several registers may load from the operand in the same cycle; all succeed and the FSM leaves READY once.

## Timing
- Every register update becomes visible on the cycle after the strobe edge.
- Address is combinational, with zero latency from addr_sel and register state.
- Assembly latency: NBYTES db_valid beats after entering COLLECT. asm_ready rises the cycle after the last beat. Minimum asm_start-to-ready time is NBYTES+1 cycles.
- db_valid outside COLLECT is ignored. asm_start during COLLECT restarts the count at 0.
- load_err is registered and pulses the cycle after the offending strobe.

## Structure
- Shared package `addr_pkg`: addr_sel encodings (ASEL_PC, ASEL_AR, ASEL_SP, ASEL_OP), FSM state enum (IDLE, COLLECT, READY), default RESET_VECTOR.
- One sub-module, `operand_assembler`: the FSM, byte counter and operand register, parametrised on ADDR_W/DATA_W. It exports operand, asm_ready and a consume input.
- PC/AR/SP update logic and the output mux stay in the top level.

## Test plan
- Reset: hold rst = 0 for 2 cycles with all strobes high → PC = 0x0000, AR = 0x0000, SP = 0xFFFF, asm_ready = 0.
- Assembly with a gap: asm_start, then db_valid with 0x34, one idle cycle, then db_valid with 0x12 → asm_ready = 1. PC_load → PC = 0x1234 and asm_ready = 0.
- Priority and wrap: PC = 0xFFFF with PC_inc and PC_load together → PC = 0x0000. PC = 0x0010, PC_rel with DataBus = 0xF0 → PC = 0x0000.
- Stack: 2× SP_push → SP = 0xFFFD. SP_push with SP_pop together → 0xFFFC. SP_pop at 0xFFFF → 0x0000.
- Errors and abort: AR_load with src_temp = 1 and no operand → AR unchanged, load_err = 1 for one cycle. asm_start, one byte, asm_abort → IDLE; a following AR_load from the operand also errors.
- Reset mid-operation: rst = 0 after the first byte of an assembly → FSM IDLE, operand 0. Repeat the whole suite with ADDR_W = 24, confirming 3-byte assembly and 24-bit wrap.

Source files
------------

// File: rtl/addr_pkg.sv
// rtl/addr_pkg.sv - shared encodings for the address-generation unit
package addr_pkg;

   localparam logic [1:0] ASEL_PC = 2'd0;
   localparam logic [1:0] ASEL_AR = 2'd1;
   localparam logic [1:0] ASEL_SP = 2'd2;
   localparam logic [1:0] ASEL_OP = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      READY   = 2'd2
   } asm_state_t;

   localparam int unsigned DEFAULT_RESET_VECTOR = 0;

endpackage

// File: rtl/operand_assembler.sv
// rtl/operand_assembler.sv - byte-serial little-endian operand builder
module operand_assembler
   import addr_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              db_valid,
   input  logic              asm_start,
   input  logic              asm_abort,
   input  logic              consume,
   output logic [ADDR_W-1:0] operand,
   output logic              asm_ready
);

   localparam int NBYTES = ADDR_W / DATA_W;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

   asm_state_t       state;
   logic [CNT_W-1:0] count;

   // abort beats start beats everything else; the operand survives both
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= '0;
         operand   <= '0;
         asm_ready <= 1'b0;
      end else if (asm_abort) begin
         state     <= IDLE;
         count     <= '0;
         asm_ready <= 1'b0;
      end else if (asm_start) begin
         state     <= COLLECT;
         count     <= '0;
         asm_ready <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (db_valid) begin
                  for (int i = 0; i < NBYTES; i++) begin
                     if (count == CNT_W'(i)) operand[i*DATA_W +: DATA_W] <= data;
                  end
                  if (count == LAST) begin
                     state     <= READY;
                     count     <= '0;
                     asm_ready <= 1'b1;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            end
            READY: begin
               if (consume) begin
                  state     <= IDLE;
                  asm_ready <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/address_unit.sv
// rtl/address_unit.sv - PC/AR/SP registers, operand assembly and address mux
module address_unit
   import addr_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
   parameter logic [ADDR_W-1:0] SP_RESET     = '1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] DataBus,
   input  logic              db_valid,
   input  logic              asm_start,
   input  logic              asm_abort,
   input  logic              src_temp,
   input  logic              PC_load,
   input  logic              PC_inc,
   input  logic              PC_rel,
   input  logic              AR_load,
   input  logic              AR_inc,
   input  logic              AR_dec,
   input  logic              SP_load,
   input  logic              SP_push,
   input  logic              SP_pop,
   input  logic [1:0]        addr_sel,
   output logic [ADDR_W-1:0] ProgramCounter,
   output logic [ADDR_W-1:0] AddressRegister,
   output logic [ADDR_W-1:0] StackPointer,
   output logic [ADDR_W-1:0] Address,
   output logic              asm_ready,
   output logic              load_err
);

   logic [ADDR_W-1:0] operand;
   logic [ADDR_W-1:0] load_src;
   logic [ADDR_W-1:0] rel_off;
   logic              pc_op_load;
   logic              ar_op_load;
   logic              sp_op_load;
   logic              op_request;
   logic              consume;

   // an operand load counts only when it wins its register's priority
   assign pc_op_load = PC_load && !PC_rel && !PC_inc;
   assign ar_op_load = AR_load && !AR_inc && !AR_dec && src_temp;
   assign sp_op_load = SP_load && !SP_push && !SP_pop && src_temp;
   assign op_request = pc_op_load || ar_op_load || sp_op_load;
   assign consume    = op_request && asm_ready;

   assign load_src = src_temp ? operand : ProgramCounter;
   assign rel_off  = ADDR_W'($signed(DataBus));

   operand_assembler #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_asm (
      .clk       (clk),
      .rst       (rst),
      .data      (DataBus),
      .db_valid  (db_valid),
      .asm_start (asm_start),
      .asm_abort (asm_abort),
      .consume   (consume),
      .operand   (operand),
      .asm_ready (asm_ready)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         ProgramCounter  <= RESET_VECTOR;
         AddressRegister <= '0;
         StackPointer    <= SP_RESET;
         load_err        <= 1'b0;
      end else begin
         if (PC_rel)
            ProgramCounter <= ProgramCounter + rel_off;
         else if (PC_inc)
            ProgramCounter <= ProgramCounter + ADDR_W'(1);
         else if (pc_op_load && asm_ready)
            ProgramCounter <= operand;

         if (AR_inc)
            AddressRegister <= AddressRegister + ADDR_W'(1);
         else if (AR_dec)
            AddressRegister <= AddressRegister - ADDR_W'(1);
         else if (AR_load && (!src_temp || asm_ready))
            AddressRegister <= load_src;

         if (SP_push)
            StackPointer <= StackPointer - ADDR_W'(1);
         else if (SP_pop)
            StackPointer <= StackPointer + ADDR_W'(1);
         else if (SP_load && (!src_temp || asm_ready))
            StackPointer <= load_src;

         load_err <= op_request && !asm_ready;
      end
   end

   always_comb begin
      Address = ProgramCounter;
      case (addr_sel)
         ASEL_PC: Address = ProgramCounter;
         ASEL_AR: Address = AddressRegister;
         ASEL_SP: Address = StackPointer;
         ASEL_OP: Address = operand;
         default: Address = ProgramCounter;
      endcase
   end

endmodule

// File: tb/tb_address_unit.sv
// tb/tb_address_unit.sv - self-checking bench for address_unit at 16 and 24 bits
module tb_address_unit;

   localparam int unsigned C_S  = 1 << 0;
   localparam int unsigned C_A  = 1 << 1;
   localparam int unsigned C_D  = 1 << 2;
   localparam int unsigned C_T  = 1 << 3;
   localparam int unsigned C_PL = 1 << 4;
   localparam int unsigned C_PI = 1 << 5;
   localparam int unsigned C_PR = 1 << 6;
   localparam int unsigned C_AL = 1 << 7;
   localparam int unsigned C_AI = 1 << 8;
   localparam int unsigned C_AD = 1 << 9;
   localparam int unsigned C_SL = 1 << 10;
   localparam int unsigned C_SU = 1 << 11;
   localparam int unsigned C_SO = 1 << 12;
   localparam int unsigned C_ALL = 32'h1FFF;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] DataBus;
   logic db_valid, asm_start, asm_abort, src_temp;
   logic PC_load, PC_inc, PC_rel, AR_load, AR_inc, AR_dec, SP_load, SP_push, SP_pop;
   logic [1:0] addr_sel;

   logic [15:0] pc16, ar16, sp16, a16;
   logic [23:0] pc24, ar24, sp24, a24;
   logic rdy16, err16, rdy24, err24;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   address_unit #(.ADDR_W(16)) u16 (
      .clk(clk), .rst(rst), .DataBus(DataBus), .db_valid(db_valid),
      .asm_start(asm_start), .asm_abort(asm_abort), .src_temp(src_temp),
      .PC_load(PC_load), .PC_inc(PC_inc), .PC_rel(PC_rel),
      .AR_load(AR_load), .AR_inc(AR_inc), .AR_dec(AR_dec),
      .SP_load(SP_load), .SP_push(SP_push), .SP_pop(SP_pop),
      .addr_sel(addr_sel), .ProgramCounter(pc16), .AddressRegister(ar16),
      .StackPointer(sp16), .Address(a16), .asm_ready(rdy16), .load_err(err16));

   address_unit #(.ADDR_W(24)) u24 (
      .clk(clk), .rst(rst), .DataBus(DataBus), .db_valid(db_valid),
      .asm_start(asm_start), .asm_abort(asm_abort), .src_temp(src_temp),
      .PC_load(PC_load), .PC_inc(PC_inc), .PC_rel(PC_rel),
      .AR_load(AR_load), .AR_inc(AR_inc), .AR_dec(AR_dec),
      .SP_load(SP_load), .SP_push(SP_push), .SP_pop(SP_pop),
      .addr_sel(addr_sel), .ProgramCounter(pc24), .AddressRegister(ar24),
      .StackPointer(sp24), .Address(a24), .asm_ready(rdy24), .load_err(err24));

   // reference model: index 0 is the 16-bit unit, index 1 the 24-bit unit
   int unsigned wid [2] = '{16, 24};
   int unsigned m_pc [2], m_ar [2], m_sp [2], m_op [2], m_cnt [2];
   int unsigned m_phase [2];   // 0 waiting, 1 collecting, 2 operand ready
   bit          m_err [2];

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int unsigned mask, sext, npc, nar, nsp, nop, ncnt, nph, src;
         bit ready, pco, aro, spo, req;
         mask = (wid[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[k]) - 1);
         if (!rst) begin
            m_pc[k] = 0; m_ar[k] = 0; m_sp[k] = mask; m_op[k] = 0;
            m_cnt[k] = 0; m_phase[k] = 0; m_err[k] = 0;
            continue;
         end
         ready = (m_phase[k] == 2);
         pco = PC_load && !PC_rel && !PC_inc;
         aro = AR_load && !AR_inc && !AR_dec && src_temp;
         spo = SP_load && !SP_push && !SP_pop && src_temp;
         req = pco || aro || spo;
         sext = DataBus[7] ? (32'hFFFF_FF00 | 32'(DataBus)) : 32'(DataBus);

         npc = m_pc[k];
         if (PC_rel) npc = (m_pc[k] + sext) & mask;
         else if (PC_inc) npc = (m_pc[k] + 1) & mask;
         else if (PC_load && ready) npc = m_op[k];

         src = src_temp ? m_op[k] : m_pc[k];
         nar = m_ar[k];
         if (AR_inc) nar = (m_ar[k] + 1) & mask;
         else if (AR_dec) nar = (m_ar[k] - 1) & mask;
         else if (AR_load && (!src_temp || ready)) nar = src;

         nsp = m_sp[k];
         if (SP_push) nsp = (m_sp[k] - 1) & mask;
         else if (SP_pop) nsp = (m_sp[k] + 1) & mask;
         else if (SP_load && (!src_temp || ready)) nsp = src;

         nop = m_op[k]; ncnt = m_cnt[k]; nph = m_phase[k];
         if (asm_abort) begin
            nph = 0; ncnt = 0;
         end else if (asm_start) begin
            nph = 1; ncnt = 0;
         end else if (m_phase[k] == 1 && db_valid) begin
            nop = (m_op[k] & ~(32'hFF << (8 * m_cnt[k]))) | (32'(DataBus) << (8 * m_cnt[k]));
            ncnt = m_cnt[k] + 1;
            if (ncnt == wid[k] / 8) begin
               nph = 2; ncnt = 0;
            end
         end else if (m_phase[k] == 2 && req) begin
            nph = 0;
         end

         m_pc[k] = npc; m_ar[k] = nar; m_sp[k] = nsp; m_op[k] = nop;
         m_cnt[k] = ncnt; m_phase[k] = nph; m_err[k] = req && !ready;
      end
   endtask

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         int unsigned dpc, dar, dsp, da, exp_a;
         bit drdy, derr;
         dpc  = (k == 0) ? 32'(pc16) : 32'(pc24);
         dar  = (k == 0) ? 32'(ar16) : 32'(ar24);
         dsp  = (k == 0) ? 32'(sp16) : 32'(sp24);
         da   = (k == 0) ? 32'(a16)  : 32'(a24);
         drdy = (k == 0) ? rdy16 : rdy24;
         derr = (k == 0) ? err16 : err24;
         case (addr_sel)
            2'd0: exp_a = m_pc[k];
            2'd1: exp_a = m_ar[k];
            2'd2: exp_a = m_sp[k];
            default: exp_a = m_op[k];
         endcase
         chk($sformatf("w%0d model pc", wid[k]), dpc, m_pc[k]);
         chk($sformatf("w%0d model ar", wid[k]), dar, m_ar[k]);
         chk($sformatf("w%0d model sp", wid[k]), dsp, m_sp[k]);
         chk($sformatf("w%0d model addr sel%0d", wid[k], addr_sel), da, exp_a);
         chk($sformatf("w%0d model asm_ready", wid[k]), 32'(drdy), 32'(m_phase[k] == 2));
         chk($sformatf("w%0d model load_err", wid[k]), 32'(derr), 32'(m_err[k]));
      end
   endtask

   task automatic drive(input bit rn, input int unsigned c, input logic [7:0] db, input logic [1:0] sel);
      rst = rn; DataBus = db; addr_sel = sel;
      asm_start = (c & C_S) != 0;  asm_abort = (c & C_A) != 0;
      db_valid  = (c & C_D) != 0;  src_temp  = (c & C_T) != 0;
      PC_load = (c & C_PL) != 0; PC_inc = (c & C_PI) != 0; PC_rel = (c & C_PR) != 0;
      AR_load = (c & C_AL) != 0; AR_inc = (c & C_AI) != 0; AR_dec = (c & C_AD) != 0;
      SP_load = (c & C_SL) != 0; SP_push = (c & C_SU) != 0; SP_pop = (c & C_SO) != 0;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   typedef struct {
      bit          rst_n;
      int unsigned ctrl;
      logic [7:0]  db;
      int unsigned pc, ar, sp;
      bit          rdy, err;
   } vec_t;

   function automatic vec_t v(input bit rn, input int unsigned c, input logic [7:0] db,
                              input int unsigned pc, input int unsigned ar, input int unsigned sp,
                              input bit rdy, input bit err);
      vec_t r;
      r.rst_n = rn; r.ctrl = c; r.db = db; r.pc = pc; r.ar = ar; r.sp = sp; r.rdy = rdy; r.err = err;
      return r;
   endfunction

   vec_t tbl[$];

   initial begin
      drive(1'b0, 0, 8'h00, 2'd0);

      // expectations below are for the 16-bit unit; both units are also tracked by the model
      tbl.push_back(v(0, C_ALL,       8'hFF, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(0, C_ALL,       8'hFF, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, 0,           8'h00, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'h34, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, 0,           8'h00, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'h12, 'h0000, 'h0000, 'hFFFF, 1, 0));
      tbl.push_back(v(1, C_PL,        8'h00, 'h1234, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_AL | C_T,  8'h00, 'h1234, 'h0000, 'hFFFF, 0, 1));
      tbl.push_back(v(1, 0,           8'h00, 'h1234, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_AL,        8'h00, 'h1234, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_PR,        8'hF0, 'h1224, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_PI,        8'h00, 'h1225, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h1225, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'hFF, 'h1225, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'hFF, 'h1225, 'h1234, 'hFFFF, 1, 0));
      tbl.push_back(v(1, C_PL,        8'h00, 'hFFFF, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_PI | C_PL, 8'h00, 'h0000, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'h10, 'h0000, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_D,         8'h00, 'h0000, 'h1234, 'hFFFF, 1, 0));
      tbl.push_back(v(1, C_PL,        8'h00, 'h0010, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_PR,        8'hF0, 'h0000, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_SU,        8'h00, 'h0000, 'h1234, 'hFFFE, 0, 0));
      tbl.push_back(v(1, C_SU,        8'h00, 'h0000, 'h1234, 'hFFFD, 0, 0));
      tbl.push_back(v(1, C_SU | C_SO, 8'h00, 'h0000, 'h1234, 'hFFFC, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h1234, 'hFFFC, 0, 0));
      tbl.push_back(v(1, C_D,         8'hFF, 'h0000, 'h1234, 'hFFFC, 0, 0));
      tbl.push_back(v(1, C_D,         8'hFF, 'h0000, 'h1234, 'hFFFC, 1, 0));
      tbl.push_back(v(1, C_SL | C_T,  8'h00, 'h0000, 'h1234, 'hFFFF, 0, 0));
      tbl.push_back(v(1, C_SO,        8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_D,         8'h55, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_A,         8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_AL | C_T,  8'h00, 'h0000, 'h1234, 'h0000, 0, 1));
      tbl.push_back(v(1, 0,           8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_S | C_A,   8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_D,         8'h77, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_D,         8'h66, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_AL | C_T,  8'h00, 'h0000, 'h1234, 'h0000, 0, 1));
      tbl.push_back(v(1, C_S,         8'h00, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(1, C_D,         8'hAB, 'h0000, 'h1234, 'h0000, 0, 0));
      tbl.push_back(v(0, 0,           8'h00, 'h0000, 'h0000, 'hFFFF, 0, 0));
      tbl.push_back(v(1, 0,           8'h00, 'h0000, 'h0000, 'hFFFF, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst_n, tbl[i].ctrl, tbl[i].db, 2'(i % 4));
         cycle();
         chk($sformatf("row%0d pc", i), 32'(pc16), tbl[i].pc);
         chk($sformatf("row%0d ar", i), 32'(ar16), tbl[i].ar);
         chk($sformatf("row%0d sp", i), 32'(sp16), tbl[i].sp);
         chk($sformatf("row%0d asm_ready", i), 32'(rdy16), 32'(tbl[i].rdy));
         chk($sformatf("row%0d load_err", i), 32'(err16), 32'(tbl[i].err));
      end

      // operand cleared by the mid-assembly reset
      drive(1'b1, 0, 8'h00, 2'd3);
      #1;
      chk("reset operand w16", 32'(a16), 0);
      chk("reset operand w24", 32'(a24), 0);

      // 3-byte assembly: the 16-bit unit is full after two bytes and ignores the third
      drive(1'b1, C_S, 8'h00, 2'd3); cycle();
      drive(1'b1, C_D, 8'h01, 2'd3); cycle();
      drive(1'b1, C_D, 8'h02, 2'd3); cycle();
      chk("w24 not ready after 2 bytes", 32'(rdy24), 0);
      chk("w16 ready after 2 bytes", 32'(rdy16), 1);
      drive(1'b1, C_D, 8'h03, 2'd3); cycle();
      chk("w24 ready after 3 bytes", 32'(rdy24), 1);
      chk("w24 operand", 32'(a24), 'h030201);
      drive(1'b1, C_PL, 8'h00, 2'd0); cycle();
      chk("w24 pc load", 32'(pc24), 'h030201);
      chk("w16 pc load", 32'(pc16), 'h0201);

      // 24-bit wrap on PC and AR
      drive(1'b1, C_S, 8'h00, 2'd0); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, C_D, 8'hFF, 2'd0); cycle();
      end
      drive(1'b1, C_PL, 8'h00, 2'd0); cycle();
      chk("w24 pc all ones", 32'(pc24), 'hFFFFFF);
      drive(1'b1, C_PI | C_AD, 8'h00, 2'd1); cycle();
      chk("w24 pc wrap", 32'(pc24), 'h000000);
      chk("w24 ar wrap", 32'(ar24), 'hFFFFFF);
      chk("w16 ar wrap", 32'(ar16), 'hFFFF);

      for (int n = 0; n < 3000; n++) begin
         int unsigned c;
         c = 0;
         if ($urandom_range(9) == 0)  c |= C_S;
         if ($urandom_range(29) == 0) c |= C_A;
         if ($urandom_range(1) == 0)  c |= C_D;
         if ($urandom_range(1) == 0)  c |= C_T;
         for (int b = 4; b < 13; b++) if ($urandom_range(5) == 0) c |= (32'd1 << b);
         drive($urandom_range(63) != 0, c, 8'($urandom), 2'($urandom));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
